mult_dispatcher: RTL

MULT_DISPATCHER -- requirements
Module: mult_dispatcher

---
 rtl/mult_dispatcher_if.sv | 33 +++
 rtl/mult_dispatcher.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mult_dispatcher_if.sv
// Bundle of upstream operand, multiplier and downstream result signals.
// The master modport is the dispatcher's view; the slave modport is the surrounding environment.
interface mult_dispatcher_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_a;
  logic [15:0]   in_b;
  logic          mul_start;
  logic [15:0]   mul_in1;
  logic [15:0]   mul_in2;
  logic [31:0]   mul_out;
  logic          mul_done;
  logic          res_valid;
  logic          res_ready;
  logic [31:0]   res_data;
  logic          busy;
  logic          err;
  logic [CW-1:0] count;

  modport master (
    input  in_valid, in_a, in_b, mul_out, mul_done, res_ready,
    output in_ready, mul_start, mul_in1, mul_in2, res_valid, res_data, busy, err, count
  );

  modport slave (
    output in_valid, in_a, in_b, mul_out, mul_done, res_ready,
    input  in_ready, mul_start, mul_in1, mul_in2, res_valid, res_data, busy, err, count
  );
endinterface

// File: rtl/mult_dispatcher.sv
// Queues operand pairs in a small FIFO and feeds them one at a time to an external
// multiplier, capturing each product and holding it until downstream accepts it.
module mult_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  mult_dispatcher_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;

  state_t          state_q, state_d;
  logic [15:0]     mem_a [DEPTH];
  logic [15:0]     mem_b [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_q;
  logic [15:0]     in1_q, in2_q;
  logic [31:0]     res_data_q;
  logic            res_valid_q;
  logic            err_q;
  logic            done_q;
  logic [TW-1:0]   tcnt_q;

  logic in_ready;
  logic push;
  logic pop;
  logic done_rise;
  logic timeout_hit;

  assign in_ready    = (count_q != CW'(DEPTH));
  assign push        = bus.in_valid && in_ready;
  assign pop         = (state_q == IDLE) && (count_q != '0);
  // Only a 0->1 transition counts, so a done level left over from the last op is ignored.
  assign done_rise   = bus.mul_done && !done_q;
  assign timeout_hit = (tcnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = START;
      START:   state_d = WAIT;
      WAIT: begin
        if (done_rise)        state_d = HOLD;
        else if (timeout_hit) state_d = IDLE;
      end
      HOLD:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Storage is not reset; occupancy and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= bus.in_a;
      mem_b[wr_ptr] <= bus.in_b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      tcnt_q      <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= bus.mul_done;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      if (pop) begin
        in1_q <= mem_a[rd_ptr];
        in2_q <= mem_b[rd_ptr];
      end

      if (state_q == START)
        tcnt_q <= '0;
      else if (state_q == WAIT && !done_rise && !timeout_hit)
        tcnt_q <= tcnt_q + TW'(1);

      if (state_q == WAIT && done_rise) begin
        res_data_q  <= bus.mul_out;
        res_valid_q <= 1'b1;
      end else if (state_q == HOLD && bus.res_ready) begin
        res_valid_q <= 1'b0;
      end

      if (state_q == WAIT && !done_rise && timeout_hit)
        err_q <= 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mul_start = (state_q == START);
  assign bus.mul_in1   = in1_q;
  assign bus.mul_in2   = in2_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.err       = err_q;
  assign bus.count     = count_q;
endmodule
